// File: rtl/reg_load_ctrl_if.sv
// Write-request handshake plus register-bank bus for reg_load_ctrl.
// master = control unit / register bank side, slave = the controller.
interface reg_load_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_addr;
  logic [7:0]       req_data;
  logic [7:0]       load_en;
  logic [7:0]       load_data;
  logic [2:0]       rb_addr;
  logic [7:0]       rb_data;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] wr_count;

  modport master (
    output req_valid, req_addr, req_data, rb_data,
    input  req_ready, load_en, load_data, rb_addr, done, err, wr_count
  );
  modport slave (
    input  req_valid, req_addr, req_data, rb_data,
    output req_ready, load_en, load_data, rb_addr, done, err, wr_count
  );
endinterface

// File: rtl/reg_load_ctrl.sv
// Register-bank write controller: strobe one register, read it back,
// retry on mismatch, report done/err and count confirmed writes.
module reg_load_ctrl #(
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic           CLK,
  input  logic           reset,
  reg_load_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;

  localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [2:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [2:0]       retry_q, retry_d;
  logic [7:0]       load_en_q, load_en_d;
  logic [7:0]       load_data_q, load_data_d;
  logic [2:0]       rb_addr_q, rb_addr_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // All outputs are computed from the next state so every one is a flop.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    retry_d     = retry_q;
    load_en_d   = '0;
    load_data_d = load_data_q;
    rb_addr_d   = rb_addr_q;
    ready_d     = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.req_valid && ready_q) begin
          addr_d      = bus.req_addr;
          data_d      = bus.req_data;
          retry_d     = '0;
          state_d     = LOAD;
          load_en_d   = 8'd1 << bus.req_addr;
          load_data_d = bus.req_data;
          rb_addr_d   = bus.req_addr;
          ready_d     = 1'b0;
        end
      end
      LOAD: state_d = CHECK;
      CHECK: begin
        if (bus.rb_data == data_q) begin
          done_d  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
          ready_d = 1'b1;
        end else if (retry_q < MAX_R) begin
          retry_d   = retry_q + 3'd1;
          state_d   = LOAD;
          load_en_d = 8'd1 << addr_q;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Async reset clears load_en immediately so no strobe survives an abort.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      retry_q     <= '0;
      load_en_q   <= '0;
      load_data_q <= '0;
      rb_addr_q   <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      retry_q     <= retry_d;
      load_en_q   <= load_en_d;
      load_data_q <= load_data_d;
      rb_addr_q   <= rb_addr_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.load_en   = load_en_q;
  assign bus.load_data = load_data_q;
  assign bus.rb_addr   = rb_addr_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.wr_count  = cnt_q;
endmodule
